state_pack__poly_tobytes: RTL and testbench

Packs a stream of Kyber polynomial coefficients into the byte-serialized form used by the key and ciphertext encoders. It is the inverse of the byte-array unpacker. Each 128-bit input beat carries eight 16-bit signed coefficients. These are canonicalized to [0, KYBER_Q) and packed as eight 12-bit fields into a 96-bit slice of a wide output register, which holds KYBER_K polynomials (6144 bits at K=2).

---
 rtl/state_pack__poly_tobytes_pkg.sv | 38 +++
 rtl/state_pack__poly_tobytes__r.sv | 39 +++
 rtl/state_pack__poly_tobytes.sv | 100 ++++++++++
 tb/tb_state_pack__poly_tobytes.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/state_pack__poly_tobytes_pkg.sv
// Shared constants, FSM encoding and stage payload for the Kyber polynomial byte packer.
// The canonicalize helper maps a signed coefficient into [0, KYBER_Q) and keeps the low 12 bits.
package state_pack__poly_tobytes_pkg;

    localparam int unsigned KYBER_K         = 2;
    localparam int unsigned KYBER_N         = 256;
    localparam int unsigned KYBER_Q         = 3329;
    localparam int unsigned BYTE_BITS       = 8;
    localparam int unsigned KYBER_POLYBYTES = 384;
    localparam int unsigned COEFF_SZ        = 16;
    localparam int unsigned LANES           = 8;
    localparam int unsigned FIELD_W         = 12;
    localparam int unsigned IPOLY_SZ        = LANES * COEFF_SZ;
    localparam int unsigned SLICE_W         = LANES * FIELD_W;
    localparam int unsigned OPOLY_SZ        = BYTE_BITS * KYBER_POLYBYTES * KYBER_K;
    localparam int unsigned BEATS           = KYBER_K * KYBER_N / LANES;
    localparam int unsigned CNT_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [CNT_W-1:0]   idx;
        logic [SLICE_W-1:0] data;
    } slice_t;

    // Negative inputs get KYBER_Q added (mod 2^16); out-of-range values simply keep their low bits.
    function automatic logic [FIELD_W-1:0] canon12(input logic [COEFF_SZ-1:0] c);
        logic [COEFF_SZ-1:0] t;
        t = c + (c[COEFF_SZ-1] ? COEFF_SZ'(KYBER_Q) : COEFF_SZ'(0));
        return t[FIELD_W-1:0];
    endfunction

endpackage

// File: rtl/state_pack__poly_tobytes__r.sv
// Stage register: canonicalizes eight 16-bit lanes and packs them into one 96-bit slice,
// tagged with the beat index it belongs to.
module state_pack__poly_tobytes__r
    import state_pack__poly_tobytes_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                valid_i,
    input  logic [CNT_W-1:0]    idx_i,
    input  logic [IPOLY_SZ-1:0] poly_i,
    output slice_t              slice_o
);

    logic [SLICE_W-1:0] pack_c;
    slice_t             slice_q;

    always_comb begin
        pack_c = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            pack_c[j*FIELD_W +: FIELD_W] = canon12(poly_i[j*COEFF_SZ +: COEFF_SZ]);
        end
    end

    // Payload only moves on an accepted beat; valid tracks acceptance every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slice_q <= '0;
        end else begin
            slice_q.valid <= valid_i;
            if (valid_i) begin
                slice_q.idx  <= idx_i;
                slice_q.data <= pack_c;
            end
        end
    end

    assign slice_o = slice_q;

endmodule

// File: rtl/state_pack__poly_tobytes.sv
// Kyber poly_tobytes packer: accepts BEATS coefficient beats in order and writes each
// packed 96-bit slice into the wide output register, pulsing Function_Done when complete.
module state_pack__poly_tobytes
    import state_pack__poly_tobytes_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [IPOLY_SZ-1:0] i_poly,
    output logic                in_ready,
    output logic                Function_Done,
    output logic [OPOLY_SZ-1:0] o_poly
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic [OPOLY_SZ-1:0] poly_q;
    logic                accept_c;
    slice_t              stage;

    assign accept_c = in_valid & ready_q;

    state_pack__poly_tobytes__r u_stage (
        .clk     (clk),
        .resetn  (resetn),
        .valid_i (accept_c),
        .idx_i   (cnt_q),
        .poly_i  (i_poly),
        .slice_o (stage)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_PACK;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end
            end
            ST_PACK: begin
                if (accept_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                ready_d = (cnt_d < CNT_W'(BEATS));
                // Finish on the edge that writes the last slice out of the stage.
                if ((cnt_q == CNT_W'(BEATS)) && stage.valid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Only the addressed slice is rewritten; the rest of the array holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            poly_q <= '0;
        end else if (stage.valid) begin
            for (int unsigned m = 0; m < BEATS; m++) begin
                if (stage.idx == CNT_W'(m)) begin
                    poly_q[m*SLICE_W +: SLICE_W] <= stage.data;
                end
            end
        end
    end

    assign in_ready      = ready_q;
    assign Function_Done = done_q;
    assign o_poly        = poly_q;

endmodule

// File: tb/tb_state_pack__poly_tobytes.sv
// Self-checking bench for state_pack__poly_tobytes: an event/cycle-count model of the packer
// compared every cycle, plus hand-computed literal expectations.
module tb_state_pack__poly_tobytes;
    import state_pack__poly_tobytes_pkg::*;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                enable = 1'b0;
    logic                in_valid = 1'b0;
    logic [IPOLY_SZ-1:0] i_poly = '0;
    logic                in_ready;
    logic                Function_Done;
    logic [OPOLY_SZ-1:0] o_poly;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_cyc   = 0;
    int done_cnt = 0;
    int last_done = -1;
    int prev_done = -1;
    int n_acc    = 0;

    state_pack__poly_tobytes dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .in_valid      (in_valid),
        .i_poly        (i_poly),
        .in_ready      (in_ready),
        .Function_Done (Function_Done),
        .o_poly        (o_poly)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (resetn && in_valid && in_ready) n_acc <= n_acc + 1;

    // Plain-arithmetic reference: reduce each signed lane into [0,Q) then keep 12 bits.
    function automatic logic [SLICE_W-1:0] model_pack(input logic [IPOLY_SZ-1:0] beat);
        logic [SLICE_W-1:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            int c;
            int t;
            c = int'($signed(beat[16*j +: 16]));
            t = (c < 0) ? c + int'(KYBER_Q) : c;
            r[12*j +: 12] = 12'(t);
        end
        return r;
    endfunction

    function automatic logic [IPOLY_SZ-1:0] beat_gen(input int pat, input int b);
        logic [IPOLY_SZ-1:0] v;
        logic [IPOLY_SZ-1:0] special;
        special = {16'h0FFF, 16'hF800, 16'h0800, 16'h0001, 16'hF300, 16'h0000, 16'h0D00, 16'hFFFF};
        v = '0;
        if (pat == 1 && b == 0) v = special;
        for (int j = 0; j < 8; j++) begin
            if (pat == 2) v[16*j +: 16] = 16'(b);
            if (pat == 3) v[16*j +: 16] = 16'(b*1237 + j*4099 + 17);
        end
        return v;
    endfunction

    // Model: run starts when enable is seen while idle; slice lands one edge after
    // acceptance; done pulses one edge after the last acceptance; idle again two edges later.
    bit                  m_busy;
    bit                  m_ready;
    bit                  m_done;
    bit                  m_pend;
    int                  m_acc;
    int                  m_done_edge;
    int                  m_next_ok;
    int                  m_pend_idx;
    logic [SLICE_W-1:0]  m_pend_data;
    logic [OPOLY_SZ-1:0] m_poly;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_done <= 1'b0; m_pend <= 1'b0;
            m_acc <= 0; m_done_edge <= -1; m_next_ok <= 0; m_pend_idx <= 0;
            m_pend_data <= '0; m_poly <= '0;
        end else begin
            if (m_pend) m_poly[m_pend_idx*SLICE_W +: SLICE_W] <= m_pend_data;
            m_pend <= 1'b0;
            m_done <= (cyc == m_done_edge);
            if (m_busy) begin
                if (in_valid && m_ready) begin
                    m_pend      <= 1'b1;
                    m_pend_idx  <= m_acc;
                    m_pend_data <= model_pack(i_poly);
                    m_acc       <= m_acc + 1;
                    if (m_acc + 1 == int'(BEATS)) begin
                        m_busy      <= 1'b0;
                        m_ready     <= 1'b0;
                        m_done_edge <= cyc + 1;
                        m_next_ok   <= cyc + 3;
                    end
                end
            end else if (enable && cyc >= m_next_ok) begin
                m_busy  <= 1'b1;
                m_acc   <= 0;
                m_ready <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [SLICE_W-1:0] got, input logic [SLICE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        int s;
        chk("in_ready", longint'(in_ready), longint'(m_ready));
        chk("Function_Done", longint'(Function_Done), longint'(m_done));
        n_checks++;
        if (o_poly !== m_poly) begin
            s = -1;
            for (int i = 0; i < int'(BEATS); i++)
                if (s < 0 && o_poly[i*SLICE_W +: SLICE_W] !== m_poly[i*SLICE_W +: SLICE_W]) s = i;
            n_fail++;
            $display("FAIL o_poly slice %0d at cycle %0d: got %h expected %h", s, cyc,
                     o_poly[s*SLICE_W +: SLICE_W], m_poly[s*SLICE_W +: SLICE_W]);
        end
        if (Function_Done === 1'b1) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
        end
    end

    task automatic run(input int pat, input bit toggle, input int extra, input bit hold,
                       input int en_at, input int abort_at);
        int b = 0;
        int g = 0;
        bit ph = 1'b1;
        bit seen = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        en_cyc = cyc;
        @(negedge clk);
        enable = hold;
        while (b < int'(BEATS) && g < 400) begin
            if (abort_at >= 0 && b == abort_at) break;
            in_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            i_poly = beat_gen(pat, b);
            enable = (en_at >= 0 && b == en_at) ? 1'b1 : hold;
            if (in_valid && in_ready) b++;
            @(negedge clk);
            g++;
            if (Function_Done) seen = 1'b1;
        end
        in_valid = 1'b0;
        if (abort_at >= 0) return;
        chk("beats fed", longint'(b), longint'(BEATS));
        for (int i = 0; i < extra; i++) begin
            in_valid = 1'b1;
            i_poly = '1;
            @(negedge clk);
            if (Function_Done) seen = 1'b1;
        end
        in_valid = 1'b0;
        g = 0;
        while (!seen && g < 200) begin
            @(negedge clk);
            g++;
            if (Function_Done) seen = 1'b1;
        end
        chk("done seen", longint'(seen), 1);
        #1;
    endtask

    initial begin : stim
        int d0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset o_poly nonzero", longint'(o_poly != '0), 0);
        chk("reset in_ready", longint'(in_ready), 0);
        chk("reset Function_Done", longint'(Function_Done), 0);
        #1 resetn = 1'b1;

        // All-zero beats, continuous valid.
        d0 = done_cnt;
        run(0, 1'b0, 0, 1'b0, -1, -1);
        chk("start-to-done cycles", longint'(last_done - en_cyc + 1), 67);
        chk("done pulses zero run", longint'(done_cnt - d0), 1);
        chk("zero run o_poly nonzero", longint'(o_poly != '0), 0);

        // Special beat 0, rest zero.
        run(1, 1'b0, 0, 1'b0, -1, -1);
        @(negedge clk);
        chk_w("special slice0", o_poly[SLICE_W-1:0], 96'hFFF501800001001000D00D00);
        chk_w("model slice0", m_poly[SLICE_W-1:0], 96'hFFF501800001001000D00D00);
        chk_w("special slice1", o_poly[2*SLICE_W-1:SLICE_W], '0);

        // Beat m = all m, valid toggling, extra valid afterwards.
        n_acc = 0;
        run(2, 1'b1, 6, 1'b0, -1, -1);
        repeat (4) @(negedge clk);
        chk("accepted beats", longint'(n_acc), 64);
        chk_w("slice63", o_poly[63*SLICE_W +: SLICE_W], {8{12'h03F}});
        chk_w("slice1", o_poly[1*SLICE_W +: SLICE_W], {8{12'h001}});

        // Enable during PACK and during DONE must not restart.
        run(3, 1'b0, 0, 1'b0, 10, -1);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        #1 d0 = done_cnt;
        repeat (80) @(negedge clk);
        #1;
        chk("no restart done", longint'(done_cnt - d0), 0);
        chk("no restart ready", longint'(in_ready), 0);

        // Reset after 20 accepted beats.
        run(3, 1'b0, 0, 1'b0, -1, 20);
        #2 resetn = 1'b0;
        #1;
        chk("midrun reset o_poly nonzero", longint'(o_poly != '0), 0);
        chk("midrun reset in_ready", longint'(in_ready), 0);
        chk("midrun reset Function_Done", longint'(Function_Done), 0);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        d0 = done_cnt;
        run(3, 1'b0, 0, 1'b0, -1, -1);
        chk("post-reset done pulses", longint'(done_cnt - d0), 1);

        // Back-to-back with enable held.
        run(2, 1'b0, 0, 1'b1, -1, -1);
        run(3, 1'b0, 0, 1'b1, -1, -1);
        enable = 1'b0;
        chk("done spacing ok", longint'((last_done - prev_done) >= 67), 1);
        chk_w("b2b slice0", o_poly[SLICE_W-1:0], 96'h02602302001D01A017014011);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
